// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants and the de-interleaver symbol record.
package rs_pkg;

  localparam int unsigned RS_N          = 255;
  localparam int unsigned RS_DEPTH_LRPT = 4;
  localparam int unsigned RS_CVCDU_LEN  = RS_N * RS_DEPTH_LRPT;

  // One de-interleaved byte plus its codeword position tags.
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] cw;
    logic       first;
    logic       last;
  } rs_sym_t;

  // Linear RAM address of (bank, codeword lane, byte position).
  // Codewords are stored contiguously, so a bank reads out codeword-major.
  function automatic int unsigned rs_bank_addr(input logic        bank,
                                               input int unsigned lane,
                                               input int unsigned pos,
                                               input int unsigned depth,
                                               input int unsigned n);
    return (bank ? depth * n : 32'd0) + lane * n + pos;
  endfunction

endpackage

// File: rtl/rs_pingpong_ram.sv
// Simple dual-port byte RAM holding both ping-pong banks; registered read.
module rs_pingpong_ram
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH_LRPT,
  parameter int unsigned N     = RS_N,
  parameter int unsigned AW    = $clog2(2 * DEPTH * N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned WORDS = 2 * DEPTH * N;

  logic [7:0] mem [WORDS];

  // Write port and one-cycle-latency read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rs_deinterleaver.sv
// RS de-interleaver: writes interleaved CVCDU bytes into a ping-pong bank
// and streams each filled bank out codeword by codeword.
module rs_deinterleaver
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH_LRPT,
  parameter int unsigned N     = RS_N
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_cvcdu,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  output logic       data_ready_out,
  output logic [7:0] symbol_out,
  output logic [2:0] cw_idx_out,
  output logic       first_out,
  output logic       last_out,
  output logic       data_valid_out,
  input  logic       data_ready_in,
  output logic       frame_drop_out
);

  localparam int unsigned AW        = $clog2(2 * DEPTH * N);
  localparam int unsigned PW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0]  LANE_LAST = 3'(DEPTH - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

  // ---------------- write side ----------------
  logic          wr_bank;
  logic [2:0]    wr_lane;
  logic [PW-1:0] wr_pos;
  logic [1:0]    full;
  logic          wr_fire;
  logic          wr_restart;
  logic          wr_done;
  logic [2:0]    eff_lane;
  logic [PW-1:0] eff_pos;
  logic [AW-1:0] wr_addr;

  assign data_ready_out = ~full[wr_bank];
  assign wr_fire        = data_valid_in & data_ready_out;
  assign wr_restart     = new_cvcdu & ((wr_lane != '0) | (wr_pos != '0));
  // A new_cvcdu byte is always stored as byte 0, whatever the counters held.
  assign eff_lane       = new_cvcdu ? '0 : wr_lane;
  assign eff_pos        = new_cvcdu ? '0 : wr_pos;
  assign wr_done        = (eff_lane == LANE_LAST) && (eff_pos == POS_LAST);
  assign wr_addr        = AW'(rs_bank_addr(wr_bank, 32'(eff_lane), 32'(eff_pos), DEPTH, N));

  // Lane steps every byte, position every DEPTH bytes: byte k -> cw k mod DEPTH, pos k div DEPTH.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_bank        <= 1'b0;
      wr_lane        <= '0;
      wr_pos         <= '0;
      frame_drop_out <= 1'b0;
    end else begin
      frame_drop_out <= wr_fire & wr_restart;
      if (wr_fire) begin
        if (wr_done) begin
          wr_lane <= '0;
          wr_pos  <= '0;
          wr_bank <= ~wr_bank;
        end else if (eff_lane == LANE_LAST) begin
          wr_lane <= '0;
          wr_pos  <= eff_pos + 1'b1;
        end else begin
          wr_lane <= eff_lane + 1'b1;
          wr_pos  <= eff_pos;
        end
      end
    end
  end

  // ---------------- read side ----------------
  logic          iss_bank;
  logic          rd_bank;
  logic [2:0]    iss_lane;
  logic [PW-1:0] iss_pos;
  logic          issue;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ram_q;
  logic          pend;
  rs_sym_t       pend_meta;
  rs_sym_t       landed;
  rs_sym_t       skid;
  logic          skid_valid;
  rs_sym_t       out_r;
  logic          out_fire;
  logic          bank_free;
  logic [1:0]    occ;

  assign out_fire  = data_valid_out & data_ready_in;
  assign bank_free = out_fire & out_r.last & (out_r.cw == LANE_LAST);
  assign occ       = {1'b0, data_valid_out} + {1'b0, skid_valid} + {1'b0, pend};
  // Issue only if the byte returning next cycle is guaranteed a slot in out_r/skid.
  assign issue     = full[iss_bank] & ((occ <= 2'd1) | ((occ == 2'd2) & out_fire));
  assign rd_addr   = AW'(rs_bank_addr(iss_bank, 32'(iss_lane), 32'(iss_pos), DEPTH, N));

  // Issue pointer runs ahead of the free pointer so the next bank can prefetch early.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      iss_bank  <= 1'b0;
      iss_lane  <= '0;
      iss_pos   <= '0;
      pend      <= 1'b0;
      pend_meta <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_meta <= '{data: 8'd0, cw: iss_lane, first: (iss_pos == '0), last: (iss_pos == POS_LAST)};
        if (iss_pos == POS_LAST) begin
          iss_pos <= '0;
          if (iss_lane == LANE_LAST) begin
            iss_lane <= '0;
            iss_bank <= ~iss_bank;
          end else begin
            iss_lane <= iss_lane + 1'b1;
          end
        end else begin
          iss_pos <= iss_pos + 1'b1;
        end
      end
    end
  end

  // Attach returning RAM data to the tags captured at issue time.
  always_comb begin
    landed      = pend_meta;
    landed.data = ram_q;
  end

  // Output register with skid slot; outputs only move when accepted or empty.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_r          <= '0;
      data_valid_out <= 1'b0;
      skid           <= '0;
      skid_valid     <= 1'b0;
      rd_bank        <= 1'b0;
    end else begin
      if (out_fire | ~data_valid_out) begin
        if (skid_valid) begin
          out_r          <= skid;
          data_valid_out <= 1'b1;
          skid_valid     <= pend;
          if (pend) skid <= landed;
        end else if (pend) begin
          out_r          <= landed;
          data_valid_out <= 1'b1;
        end else begin
          data_valid_out <= 1'b0;
        end
      end else if (pend) begin
        skid       <= landed;
        skid_valid <= 1'b1;
      end
      if (bank_free) rd_bank <= ~rd_bank;
    end
  end

  // Fill and free always target different banks, so both events can land together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      full <= '0;
    end else begin
      if (wr_fire & wr_done) full[wr_bank] <= 1'b1;
      if (bank_free)         full[rd_bank] <= 1'b0;
    end
  end

  assign symbol_out = out_r.data;
  assign cw_idx_out = out_r.cw;
  assign first_out  = out_r.first;
  assign last_out   = out_r.last;

  rs_pingpong_ram #(
    .DEPTH (DEPTH),
    .N     (N),
    .AW    (AW)
  ) u_ram (
    .clk     (clk_in),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule
